// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter onto a single shared memory-map port.
//
// Grants are combinational: a requesting master sees mN_gnt in the same
// cycle and its addr/wrdata/memop/we drive mem_*. Read data returns one
// cycle after the grant and is steered to the master recorded in a
// registered owner tag.
//
// Arbitration when both masters request:
//   1. an active lock owner (previous grant had lock=1, still requesting,
//      lock count below MAX_LOCK) keeps the bus;
//   2. a lock owner whose count has reached MAX_LOCK hands over to the other;
//   3. otherwise the round-robin pointer rr decides (rr flips to the other
//      master after every grant).
//
// Build option: with ARB_FIXED_PRIO_EN, step 3 always selects m0 and the
// rr register is absent; locking behaves the same in both builds.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mN_req/addr/wrdata/memop/we/lock   master N request side (N = 0, 1)
//   mN_gnt                      master N access issued this cycle
//   mN_rdvalid, mN_rddata       master N read return (data is 0 when not valid)
//   mem_addr/wrdata/memop/we    shared memory request (0 when nothing granted)
//   mem_rddata                  shared read data, one cycle after the address

module mem_arbiter #(
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wrdata,
    input  logic [2:0]  m0_memop,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rdvalid,
    output logic [31:0] m0_rddata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wrdata,
    input  logic [2:0]  m1_memop,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rdvalid,
    output logic [31:0] m1_rddata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_rddata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    logic          lock_vld;   // lock_own had lock=1 on its last grant
    logic          lock_own;   // 0 = m0, 1 = m1
    logic [CW-1:0] lock_cnt;
    logic          rd_vld;     // read issued last cycle
    logic          rd_own;     // master that issued it
`ifndef ARB_FIXED_PRIO_EN
    logic          rr;         // 0 = m0 favoured, 1 = m1 favoured
`endif

    logic owner_req;
    logic lock_hold;
    logic lock_full;
    logic pick;                // contended winner: 0 = m0, 1 = m1
    logic any_gnt;
    logic sel_lock;
    logic sel_we;

    always_comb begin
        owner_req = lock_own ? m1_req : m0_req;
        lock_hold = lock_vld && owner_req && (lock_cnt < LOCK_MAX);
        lock_full = lock_vld && owner_req && (lock_cnt >= LOCK_MAX);

        if (lock_hold) begin
            pick = lock_own;
        end else if (lock_full) begin
            pick = ~lock_own;
        end else begin
`ifdef ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = rr;
`endif
        end

        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = ~pick;
                m1_gnt = pick;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
        any_gnt = m0_gnt | m1_gnt;
    end

    always_comb begin
        mem_addr   = 32'd0;
        mem_wrdata = 32'd0;
        mem_memop  = 3'd0;
        mem_we     = 1'b0;
        sel_lock   = 1'b0;
        sel_we     = 1'b0;
        if (m1_gnt) begin
            mem_addr   = m1_addr;
            mem_wrdata = m1_wrdata;
            mem_memop  = m1_memop;
            mem_we     = m1_we;
            sel_lock   = m1_lock;
            sel_we     = m1_we;
        end else if (m0_gnt) begin
            mem_addr   = m0_addr;
            mem_wrdata = m0_wrdata;
            mem_memop  = m0_memop;
            mem_we     = m0_we;
            sel_lock   = m0_lock;
            sel_we     = m0_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_own <= 1'b0;
            lock_cnt <= '0;
            rd_vld   <= 1'b0;
            rd_own   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr       <= 1'b0;
`endif
        end else begin
`ifndef ARB_FIXED_PRIO_EN
            if (any_gnt) begin
                rr <= m0_gnt;
            end
`endif
            // Any grant without lock, an ownership change, or an idle cycle
            // (owner dropped req) ends the current lock run.
            if (any_gnt && sel_lock) begin
                lock_vld <= 1'b1;
                lock_own <= m1_gnt;
                if (lock_vld && (lock_own == m1_gnt)) begin
                    if (lock_cnt < LOCK_MAX) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end else begin
                    lock_cnt <= CW'(1);
                end
            end else begin
                lock_vld <= 1'b0;
                lock_own <= 1'b0;
                lock_cnt <= '0;
            end
            rd_vld <= any_gnt && !sel_we;
            rd_own <= m1_gnt;
        end
    end

    assign m0_rdvalid = rd_vld && !rd_own;
    assign m1_rdvalid = rd_vld && rd_own;
    assign m0_rddata  = m0_rdvalid ? mem_rddata : 32'd0;
    assign m1_rddata  = m1_rdvalid ? mem_rddata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Expected values for the contended cases
// depend on whether ARB_FIXED_PRIO_EN is defined for the build.

module tb_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rdvalid;
    logic [31:0] m0_addr, m0_wrdata, m0_rddata;
    logic [2:0]  m0_memop;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rdvalid;
    logic [31:0] m1_addr, m1_wrdata, m1_rddata;
    logic [2:0]  m1_memop;
    logic [31:0] mem_addr, mem_wrdata, mem_rddata;
    logic [2:0]  mem_memop;
    logic        mem_we;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.MAX_LOCK(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wrdata(m0_wrdata),
        .m0_memop(m0_memop), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rdvalid(m0_rdvalid), .m0_rddata(m0_rddata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wrdata(m1_wrdata),
        .m1_memop(m1_memop), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rdvalid(m1_rdvalid), .m1_rddata(m1_rddata),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_memop(mem_memop),
        .mem_we(mem_we), .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic e1;
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = 32'h1; m0_wrdata = 32'h0; m0_memop = 3'd0; m0_we = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_addr = 32'h2; m1_wrdata = 32'h0; m1_memop = 3'd0; m1_we = 1'b0; m1_lock = 1'b0;
        mem_rddata = 32'hDEADBEEF;
        tick();

        // Requests during reset are not granted and mem_* stays 0.
        m0_req = 1'b1; m1_req = 1'b1;
        #2;
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick();
        chk("rst_m0_rdvalid", {31'd0, m0_rdvalid}, 32'd0);
        chk("rst_m1_rdvalid", {31'd0, m1_rdvalid}, 32'd0);
        chk("rst_m0_rddata", m0_rddata, 32'd0);
        chk("rst_m1_rddata", m1_rddata, 32'd0);

        // Both masters request 4 writes starting the first cycle after reset.
        rst = 1'b0;
        m0_we = 1'b1; m0_addr = 32'h1000; m0_wrdata = 32'hA0;
        m1_we = 1'b1; m1_addr = 32'h2000; m1_wrdata = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            #2;
            e1 = FIXED ? 1'b0 : i[0];
            chk($sformatf("rr_m0_gnt_%0d", i), {31'd0, m0_gnt}, {31'd0, ~e1});
            chk($sformatf("rr_m1_gnt_%0d", i), {31'd0, m1_gnt}, {31'd0, e1});
            chk($sformatf("rr_mem_addr_%0d", i), mem_addr, e1 ? 32'h2000 : 32'h1000);
            tick();
        end
        m0_req = 1'b0;
        #2;
        chk("tail_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("tail_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        tick();
        idle();
        #2;
        chk("idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wrdata", mem_wrdata, 32'd0);
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        tick();

        // Single m0 read, then an m1 read overlapping the m0 data return.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0010_0010; m0_memop = 3'b010;
        #2;
        chk("rd0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rd0_mem_addr", mem_addr, 32'h0010_0010);
        chk("rd0_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd0_mem_memop", {29'd0, mem_memop}, 32'd2);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_memop = 3'b101;
        #2;
        chk("rd0_rdvalid", {31'd0, m0_rdvalid}, 32'd1);
        chk("rd0_rddata", m0_rddata, 32'hDEADBEEF);
        chk("rd0_m1_rdvalid", {31'd0, m1_rdvalid}, 32'd0);
        chk("rd0_m1_rddata", m1_rddata, 32'd0);
        chk("rd1_gnt_pipelined", {31'd0, m1_gnt}, 32'd1);
        chk("rd1_mem_memop", {29'd0, mem_memop}, 32'd5);
        tick();
        m1_req = 1'b0;
        mem_rddata = 32'h1234_5678;
        #2;
        chk("rd1_rdvalid", {31'd0, m1_rdvalid}, 32'd1);
        chk("rd1_rddata", m1_rddata, 32'h1234_5678);
        chk("rd1_m0_rdvalid", {31'd0, m0_rdvalid}, 32'd0);
        chk("rd1_m0_rddata", m0_rddata, 32'd0);
        tick();

        // m0 write: visible on mem_* same cycle, no read return.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0030_0000; m0_wrdata = 32'h41;
        #2;
        chk("wr_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h0030_0000);
        chk("wr_mem_wrdata", mem_wrdata, 32'h41);
        tick();
        m0_req = 1'b0;
        #2;
        chk("wr_m0_rdvalid", {31'd0, m0_rdvalid}, 32'd0);
        chk("wr_m1_rdvalid", {31'd0, m1_rdvalid}, 32'd0);
        tick();

        // Reset lands on an m1 read request after m0 moved rr to m1.
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0;
        rst = 1'b1;
        #2;
        chk("rstrd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rstrd_mem_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
        #2;
        chk("rstrd_m1_rdvalid", {31'd0, m1_rdvalid}, 32'd0);
        chk("rstrd_rr_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rstrd_rr_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        tick();

        // m1 locked for 20 cycles while m0 requests throughout.
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #2;
            e1 = FIXED ? 1'b0 : ((c >= 1 && c <= 16) || c >= 18);
            chk($sformatf("lock_m1_gnt_%0d", c), {31'd0, m1_gnt}, {31'd0, e1});
            chk($sformatf("lock_m0_gnt_%0d", c), {31'd0, m0_gnt}, {31'd0, ~e1});
            tick();
        end

        // Lock holds against rr, and ends once the owner drops lock.
        do_reset();
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("hold_solo_%0d", c), {31'd0, m1_gnt}, 32'd1);
            tick();
        end
        m0_req = 1'b1;
        #2;
        chk("hold_vs_rr", {31'd0, m1_gnt}, 32'd1);
        tick();
        m1_lock = 1'b0;
        #2;
        chk("hold_last", {31'd0, m1_gnt}, 32'd1);
        tick();
        #2;
        chk("hold_released", {31'd0, m0_gnt}, 32'd1);
        tick();

        // Count saturates with m1 alone; m0 then takes over immediately.
        do_reset();
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #2;
            chk($sformatf("sat_m1_gnt_%0d", c), {31'd0, m1_gnt}, 32'd1);
            tick();
        end
        m0_req = 1'b1;
        #2;
        chk("sat_handover_m0", {31'd0, m0_gnt}, 32'd1);
        chk("sat_handover_m1", {31'd0, m1_gnt}, 32'd0);
        tick();
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
